// File: rtl/moore_step_ctrl.sv
// ---------------------------------------------------------------------------
// moore_step_ctrl
//
// Input-conditioning and stepping stage in front of the 2-state Moore puzzle
// machine. Raw board switches and buttons are synchronised and debounced.
// A clean step press becomes a single-cycle ctrl_out pulse, and sw_out is
// held stable around that pulse. A load press re-initialises the machine
// through fsm_reset/state_init.
//
// Ports
//   clk         system clock
//   reset       synchronous active-high reset
//   btn_step    raw step button (async, bouncy)
//   btn_load    raw load button (async, bouncy)
//   sw_raw      raw switch vector (async)
//   init_raw    raw initial-state switches (async)
//   sw_out      switch value presented to the machine, changes only on a step
//   ctrl_out    one-cycle step pulse to the machine
//   state_init  initial state presented to the machine
//   fsm_reset   reset to the machine, high while loading
//   step_count  steps since the last load, saturating at 255
//   busy        high whenever the controller is not idle
//
// FSM states
//   state | meaning
//   LOAD  | machine held in reset for 2 cycles, state_init captured on entry
//   IDLE  | waiting for a load request or a step press
//   SETUP | sw_out just updated, machine next-state logic settling
//   STEP  | ctrl_out high for this single cycle
//   HOLD  | waiting for the step button to be released
// ---------------------------------------------------------------------------

// Debounce filter for one signal or one vector treated as a whole.
//   clk, reset  clock and synchronous reset
//   din         synchronised input
//   dout        debounced value
module moore_step_ctrl_db #(
    parameter int W         = 1,
    parameter int DB_CYCLES = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    localparam logic [15:0] DB_TC = 16'(DB_CYCLES);

    logic [15:0] cnt;

    // The count only advances while the input disagrees with the output, so
    // any disagreement shorter than DB_CYCLES cycles is discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout <= '0;
            cnt  <= '0;
        end else if (din == dout) begin
            cnt <= '0;
        end else if (cnt + 16'd1 == DB_TC) begin
            dout <= din;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

module moore_step_ctrl #(
    parameter int                 SW_W       = 2,
    parameter int                 STATE_W    = 3,
    parameter int                 DB_CYCLES  = 16,
    parameter logic [STATE_W-1:0] INIT_STATE = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_step,
    input  logic               btn_load,
    input  logic [SW_W-1:0]    sw_raw,
    input  logic [STATE_W-1:0] init_raw,
    output logic [SW_W-1:0]    sw_out,
    output logic               ctrl_out,
    output logic [STATE_W-1:0] state_init,
    output logic               fsm_reset,
    output logic [7:0]         step_count,
    output logic               busy
);

    localparam logic [2:0] ST_LOAD  = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_SETUP = 3'd2;
    localparam logic [2:0] ST_STEP  = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;

    // -----------------------------------------------------------------------
    // Two-flop synchronisers
    // -----------------------------------------------------------------------
    logic               step_s1, step_s2;
    logic               load_s1, load_s2;
    logic [SW_W-1:0]    sw_s1, sw_s2;
    logic [STATE_W-1:0] init_s1, init_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            step_s1 <= 1'b0;
            step_s2 <= 1'b0;
            load_s1 <= 1'b0;
            load_s2 <= 1'b0;
            sw_s1   <= '0;
            sw_s2   <= '0;
            init_s1 <= '0;
            init_s2 <= '0;
        end else begin
            step_s1 <= btn_step;
            step_s2 <= step_s1;
            load_s1 <= btn_load;
            load_s2 <= load_s1;
            sw_s1   <= sw_raw;
            sw_s2   <= sw_s1;
            init_s1 <= init_raw;
            init_s2 <= init_s1;
        end
    end

    // -----------------------------------------------------------------------
    // Debounce
    // -----------------------------------------------------------------------
    logic               db_step, db_load;
    logic [SW_W-1:0]    db_sw;
    logic [STATE_W-1:0] db_init;

    moore_step_ctrl_db #(.W(1), .DB_CYCLES(DB_CYCLES)) u_db_step (
        .clk   (clk),
        .reset (reset),
        .din   (step_s2),
        .dout  (db_step)
    );

    moore_step_ctrl_db #(.W(1), .DB_CYCLES(DB_CYCLES)) u_db_load (
        .clk   (clk),
        .reset (reset),
        .din   (load_s2),
        .dout  (db_load)
    );

    moore_step_ctrl_db #(.W(SW_W), .DB_CYCLES(DB_CYCLES)) u_db_sw (
        .clk   (clk),
        .reset (reset),
        .din   (sw_s2),
        .dout  (db_sw)
    );

    moore_step_ctrl_db #(.W(STATE_W), .DB_CYCLES(DB_CYCLES)) u_db_init (
        .clk   (clk),
        .reset (reset),
        .din   (init_s2),
        .dout  (db_init)
    );

    // -----------------------------------------------------------------------
    // Rising-edge detect on the debounced buttons
    // -----------------------------------------------------------------------
    logic db_step_d, db_load_d;
    logic step_rise, load_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            db_step_d <= 1'b0;
            db_load_d <= 1'b0;
        end else begin
            db_step_d <= db_step;
            db_load_d <= db_load;
        end
    end

    assign step_rise = db_step & ~db_step_d;
    assign load_rise = db_load & ~db_load_d;

    // -----------------------------------------------------------------------
    // Controller FSM
    // -----------------------------------------------------------------------
    logic [2:0] state, state_nx;
    logic       load_cnt, load_cnt_nx;
    logic       load_pending;
    logic       enter_load;
    logic       enter_setup;

    // A load request seen in the same cycle as a step edge wins; the step
    // edge is dropped because edges are never queued.
    always_comb begin
        state_nx    = state;
        load_cnt_nx = load_cnt;
        case (state)
            ST_LOAD: begin
                if (load_cnt == 1'b1) begin
                    state_nx = ST_IDLE;
                end else begin
                    load_cnt_nx = load_cnt + 1'b1;
                end
            end
            ST_IDLE: begin
                if (load_pending || load_rise) begin
                    state_nx    = ST_LOAD;
                    load_cnt_nx = 1'b0;
                end else if (step_rise) begin
                    state_nx = ST_SETUP;
                end
            end
            ST_SETUP: state_nx = ST_STEP;
            ST_STEP:  state_nx = ST_HOLD;
            ST_HOLD: begin
                if (!db_step) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx    = ST_LOAD;
                load_cnt_nx = 1'b0;
            end
        endcase
    end

    assign enter_load  = (state == ST_IDLE) && (state_nx == ST_LOAD);
    assign enter_setup = (state == ST_IDLE) && (state_nx == ST_SETUP);

    // Outputs are registered from the next state so that none of them has a
    // combinational path back to an input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_LOAD;
            load_cnt     <= 1'b0;
            load_pending <= 1'b0;
            sw_out       <= '0;
            state_init   <= INIT_STATE;
            step_count   <= 8'd0;
            ctrl_out     <= 1'b0;
            fsm_reset    <= 1'b1;
            busy         <= 1'b1;
        end else begin
            state        <= state_nx;
            load_cnt     <= load_cnt_nx;
            load_pending <= enter_load ? 1'b0 : (load_pending | load_rise);

            if (enter_setup) begin
                sw_out <= db_sw;
            end

            if (enter_load) begin
                state_init <= db_init;
                step_count <= 8'd0;
            end else if ((state == ST_STEP) && (step_count != 8'hFF)) begin
                step_count <= step_count + 8'd1;
            end

            ctrl_out  <= (state_nx == ST_STEP);
            fsm_reset <= (state_nx == ST_LOAD);
            busy      <= (state_nx != ST_IDLE);
        end
    end

endmodule

// File: doc/moore_step_ctrl.md
Name: moore_step_ctrl

Overview:
- Input-conditioning and stepping stage that sits directly upstream of the 2-state Moore puzzle machine.
- Synchronises and debounces the raw board switches, step button and load button.
- Drives the machine's sw_in, ctrl_in, state_in and reset inputs.
- Guarantees sw_in is stable before, during and after every single-cycle step pulse.

Parameters:
- SW_W, 2, width of switch vector (matches machine sw_in)
- STATE_W, 3, width of state vector (matches machine state_in)
- DB_CYCLES, 16, consecutive identical synced samples before a debounced value changes; legal range 1..65535
- INIT_STATE, 0, state_init value after reset

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- btn_step  in  1  raw step push-button, asynchronous, bouncy
- btn_load  in  1  raw load push-button, asynchronous, bouncy
- sw_raw  in  SW_W  raw input switches, asynchronous
- init_raw  in  STATE_W  raw initial-state switches, asynchronous
- sw_out  out  SW_W  to machine sw_in; held stable
- ctrl_out  out  1  to machine ctrl_in; one-cycle step pulse
- state_init  out  STATE_W  to machine state_in
- fsm_reset  out  1  to machine reset
- step_count  out  8  steps since last load, saturating
- busy  out  1  high whenever the controller is not in IDLE

Behaviour:
- Clock and reset: one clock domain, clk. reset is synchronous and active-high.
- Reset values: sw_out=0, ctrl_out=0, state_init=INIT_STATE, fsm_reset=1, step_count=0, busy=1. Synchroniser and debounce state cleared to 0, load_pending=0. FSM goes to LOAD with load counter=0.
- Synchronisers: btn_step, btn_load, sw_raw and init_raw each pass through 2 flops.
- Debounce:
  - Each debounced signal has its own counter: step, load, the sw vector as a whole, and the init vector as a whole.
  - While the synced value equals the debounced value, the counter is 0.
  - Otherwise the counter increments. When it reaches DB_CYCLES, the debounced value takes the synced value and the counter clears.
  - A glitch shorter than DB_CYCLES cycles never changes the debounced value.
- Edge detect: step_rise and load_rise fire for one cycle on a 0->1 transition of the debounced value.
- load_pending: set on load_rise in any state. Cleared when LOAD is entered.
- FSM states and transitions:
  - LOAD
    - fsm_reset=1; state_init driven from debounced init, or INIT_STATE if entered from reset.
    - step_count cleared.
    - Stays exactly 2 cycles, then goes to IDLE.
  - IDLE
    - busy=0, fsm_reset=0.
    - If load_pending, go to LOAD. This takes priority over a step.
    - Else if step_rise, latch sw_out <= debounced sw and go to SETUP.
  - SETUP: 1 cycle, so the machine's combinational next-state settles on the new sw_out. Then go to STEP.
  - STEP
    - ctrl_out=1 for exactly this cycle.
    - step_count increments, saturating at 255.
    - Then go to HOLD.
  - HOLD: wait until debounced step = 0, then go to IDLE.
- Step latency: step_rise in cycle N gives sw_out updated at N+1 and ctrl_out high in cycle N+2 only.
- Step edges outside IDLE: ignored, never queued. One button press produces at most one ctrl_out pulse.
- sw_out stability: sw_out changes only on the IDLE->SETUP transition. Switch motion at any other time is not visible to the machine.
- state_init stability: state_init changes only on entry to LOAD, and holds its value afterwards.
- Registered outputs: ctrl_out and fsm_reset are registered, with no combinational path from any input.
- Reset mid-operation: reset in any state aborts it. Outputs take their reset values on the next edge, with no partial ctrl_out pulse.
- Simultaneous load_rise and step_rise in IDLE: LOAD wins and the step is dropped.

Test Plan:
- Reset with DB_CYCLES=4, INIT_STATE=0, then release -> fsm_reset=1 for exactly 2 cycles after reset drops; state_init=0, step_count=0, ctrl_out never high.
- sw_raw=2'b10, btn_step held high 20 cycles then low -> exactly one ctrl_out pulse, in cycle N+2 after step_rise; sw_out=2'b10 at that pulse; step_count=1; busy low after release debounces.
- btn_step bounces 3-cycle pulses for 30 cycles, then stable high -> exactly one ctrl_out pulse in total.
- sw_raw toggles 01/11 every 2 cycles while in HOLD -> sw_out unchanged; next clean step latches the value stable for at least 4 cycles.
- init_raw=3'b001, press btn_load while in HOLD -> LOAD entered only after return to IDLE; state_init=1, fsm_reset=1 for 2 cycles, step_count=0.
- 300 clean step presses -> step_count saturates at 255; reset asserted during SETUP -> no ctrl_out, all outputs at reset values next cycle.
